// File: rtl/framebuffer_window_if.sv
// framebuffer_window_if: request/response bus between the convolution engine and the framebuffer
interface framebuffer_window_if #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_BITS = 4,
  parameter int WORD_PIX = 8,
  parameter int KERNEL = 5
);
  logic [WORD_PIX*PIX_BITS-1:0] data_in;
  logic [$clog2(WIDTH)-1:0] x_pos;
  logic [$clog2(HEIGHT)-1:0] y_pos;
  logic write;
  logic read;
  logic border_mode;
  logic busy;
  logic [KERNEL*KERNEL*PIX_BITS-1:0] data_chunk;
  logic data_ready;
  logic wr_err;
  modport master (
    output data_in, x_pos, y_pos, write, read, border_mode,
    input busy, data_chunk, data_ready, wr_err
  );
  modport slave (
    input data_in, x_pos, y_pos, write, read, border_mode,
    output busy, data_chunk, data_ready, wr_err
  );
endinterface

// File: rtl/framebuffer_window.sv
// framebuffer_window: packed-pixel framebuffer returning KERNEL x KERNEL windows; optional RAM sweep via FRAMEBUFFER_WINDOW_CLEAR_EN
module framebuffer_window #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_BITS = 4,
  parameter int WORD_PIX = 8,
  parameter int KERNEL = 5
) (
  input logic clk,
  input logic reset,
`ifdef FRAMEBUFFER_WINDOW_CLEAR_EN
  input logic clear,
`endif
  framebuffer_window_if.slave bus
);
  localparam int HALF = (KERNEL - 1) / 2;
  localparam int WPR = WIDTH / WORD_PIX;
  localparam int DEPTH = WPR * HEIGHT;
  localparam int ADW = $clog2(DEPTH);
  localparam int AW = $clog2(WIDTH > HEIGHT ? WIDTH : HEIGHT) + 2;
  localparam int LWP = $clog2(WORD_PIX);
  localparam int WW = WORD_PIX * PIX_BITS;
  localparam int RW = KERNEL * PIX_BITS;
  typedef logic signed [AW-1:0] coord_t;
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    FETCH,
`ifdef FRAMEBUFFER_WINDOW_CLEAR_EN
    DONE,
    CLEAR
`else
    DONE
`endif
  } state_t;
  state_t state, next_state;
  logic [ADW-1:0] cnt, p_cnt, addr;
  logic [$clog2(WIDTH)-1:0] xr;
  logic [$clog2(HEIGHT)-1:0] yr;
  logic mode, p_v, we, in_rng, clr_on;
  logic [WW-1:0] wdata, rdata, lo;
  logic [2*WW-1:0] pair;
  logic [RW-1:0] row_pix;
  logic [KERNEL*RW-1:0] asm_q, chunk;
  logic [WW-1:0] mem [DEPTH];
  coord_t cx, cy, w0, wi, ri, pr, c, idx;
  function automatic coord_t clamp(input coord_t v, input coord_t hi);
    return v < 0 ? '0 : (v > hi ? hi : v);
  endfunction
`ifdef FRAMEBUFFER_WINDOW_CLEAR_EN
  assign clr_on = state == CLEAR;
`else
  assign clr_on = 1'b0;
`endif
  assign bus.busy = state != IDLE;
  assign bus.data_ready = state == DONE;
  assign bus.wr_err = state == WRITE && !in_rng;
  assign bus.data_chunk = chunk;
  // next-state: clear beats write beats read; fetch runs its issue slots plus two drain cycles
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = bus.write ? WRITE : bus.read ? FETCH : IDLE;
      FETCH: next_state = cnt == ADW'(2 * KERNEL + 1) ? DONE : FETCH;
      default: next_state = IDLE;
    endcase
`ifdef FRAMEBUFFER_WINDOW_CLEAR_EN
    if (state == IDLE && clear) next_state = CLEAR;
    if (state == CLEAR) next_state = cnt == ADW'(DEPTH - 1) ? IDLE : CLEAR;
`endif
  end
  // address generation and pixel selection for the row whose second word is on the RAM output
  always_comb begin
    cx = clamp(coord_t'(xr), coord_t'(WIDTH - 1));
    cy = clamp(coord_t'(yr), coord_t'(HEIGHT - 1));
    w0 = clamp(cx - coord_t'(HALF), coord_t'(WIDTH - 1)) >>> LWP;
    wi = clamp(w0 + coord_t'(cnt[0]), coord_t'(WPR - 1));
    ri = clamp(cy - coord_t'(HALF) + coord_t'(cnt >> 1), coord_t'(HEIGHT - 1));
    in_rng = int'(xr) < WIDTH && int'(yr) < HEIGHT;
    we = clr_on || (state == WRITE && in_rng);
    addr = clr_on ? cnt : state == WRITE ? ADW'(yr) * ADW'(WPR) + ADW'(xr >> LWP) : ADW'(ri) * ADW'(WPR) + ADW'(wi);
    pr = cy - coord_t'(HALF) + coord_t'(p_cnt >> 1);
    pair = {rdata, lo};
    row_pix = '0;
    c = '0;
    idx = '0;
    for (int k = 0; k < KERNEL; k++) begin
      c = cx - coord_t'(HALF) + coord_t'(k);
      idx = clamp(c, coord_t'(WIDTH - 1)) - (w0 <<< LWP);
      row_pix[k*PIX_BITS +: PIX_BITS] = (!mode && (pr < 0 || pr > coord_t'(HEIGHT - 1) || c < 0 || c > coord_t'(WIDTH - 1))) ? '0 : pair[int'(idx)*PIX_BITS +: PIX_BITS];
    end
  end
  // single-port RAM with one-cycle registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= clr_on ? '0 : wdata;
    rdata <= mem[addr];
  end
  // state, request latches, row assembly and window publication
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      xr <= '0;
      yr <= '0;
      mode <= 1'b0;
      wdata <= '0;
      p_v <= 1'b0;
      p_cnt <= '0;
      lo <= '0;
      asm_q <= '0;
      chunk <= '0;
    end else begin
      state <= next_state;
      cnt <= state == next_state ? cnt + 1'b1 : '0;
      if (state == IDLE) begin
        xr <= bus.x_pos;
        yr <= bus.y_pos;
        mode <= bus.border_mode;
        wdata <= bus.data_in;
      end
      p_v <= state == FETCH && cnt < ADW'(2 * KERNEL);
      p_cnt <= cnt;
      if (p_v && !p_cnt[0]) lo <= rdata;
      if (p_v && p_cnt[0]) asm_q[int'(p_cnt >> 1)*RW +: RW] <= row_pix;
      if (next_state == DONE) chunk <= asm_q;
    end
  end
endmodule

// File: tb/tb_framebuffer_window.sv
// tb_framebuffer_window: directed checks of writes, window reads, borders, handshake and reset
module tb_framebuffer_window;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  int lat;
  framebuffer_window_if bus ();
`ifdef FRAMEBUFFER_WINDOW_CLEAR_EN
  logic clear = 1'b0;
`endif
  framebuffer_window dut (
    .clk(clk),
    .reset(reset),
`ifdef FRAMEBUFFER_WINDOW_CLEAR_EN
    .clear(clear),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && bus.busy; i++) tick();
  endtask

  task automatic wr(input int x, input int y, input logic [31:0] d);
    wait_idle();
    bus.x_pos = 10'(x);
    bus.y_pos = 9'(y);
    bus.data_in = d;
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    tick();
  endtask

  task automatic rd(input int x, input int y, input logic m, output int l);
    wait_idle();
    bus.x_pos = 10'(x);
    bus.y_pos = 9'(y);
    bus.border_mode = m;
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    l = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus.data_ready) begin
        l = n;
        break;
      end
    end
  endtask

  function automatic logic [99:0] exp_pat(input int cy, input logic m);
    logic [99:0] e = '0;
    for (int r = 0; r < 5; r++) begin
      int yy = cy - 2 + r;
      if (m) yy = yy < 0 ? 0 : yy > 479 ? 479 : yy;
      if (yy >= 0 && yy <= 479) e[r*20 +: 20] = {4'(15 - yy % 16), 4'(yy % 16), 4'(yy % 16), 4'(yy % 16), 4'(yy % 16)};
    end
    return e;
  endfunction

  task automatic test_reset();
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.border_mode = 1'b0;
    bus.x_pos = '0;
    bus.y_pos = '0;
    bus.data_in = '0;
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.data_ready !== 1'b0 || bus.wr_err !== 1'b0 || bus.data_chunk !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b ready=%b wr_err=%b chunk=%h, want all zero", bus.busy, bus.data_ready, bus.wr_err, bus.data_chunk);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    wr(576, 8, 32'h88888888);
    wr(584, 8, 32'h77777777);
    rd(582, 8, 1'b0, lat);
    checks++;
    if (lat !== 12) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 12", lat);
    end
    checks++;
    if (bus.data_chunk[59:40] !== 20'h78888) begin
      errors++;
      $display("FAIL basic_row2: got %h want 78888", bus.data_chunk[59:40]);
    end
    tick();
    checks++;
    if (bus.data_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_pulse: data_ready still %b one cycle later, want 0", bus.data_ready);
    end
  endtask

  task automatic test_pattern();
    for (int y = 0; y < 480; y++) begin
      wr(576, y, 32'(y % 16) * 32'h11111111);
      wr(584, y, 32'(15 - y % 16) * 32'h11111111);
    end
    for (int y = 0; y < 480; y++) begin
      rd(582, y, 1'b0, lat);
      checks++;
      if (lat !== 12 || bus.data_chunk !== exp_pat(y, 1'b0)) begin
        errors++;
        $display("FAIL pattern_y%0d: lat=%0d chunk=%h want lat=12 chunk=%h", y, lat, bus.data_chunk, exp_pat(y, 1'b0));
      end
    end
    rd(582, 500, 1'b1, lat);
    checks++;
    if (bus.data_chunk !== exp_pat(479, 1'b1)) begin
      errors++;
      $display("FAIL centre_clamp_y_clamp: got %h want %h", bus.data_chunk, exp_pat(479, 1'b1));
    end
    rd(582, 500, 1'b0, lat);
    checks++;
    if (bus.data_chunk !== exp_pat(479, 1'b0)) begin
      errors++;
      $display("FAIL centre_clamp_y_zero: got %h want %h", bus.data_chunk, exp_pat(479, 1'b0));
    end
    rd(582, 0, 1'b1, lat);
    checks++;
    if (bus.data_chunk !== exp_pat(0, 1'b1)) begin
      errors++;
      $display("FAIL top_clamp: got %h want %h", bus.data_chunk, exp_pat(0, 1'b1));
    end
  endtask

  task automatic test_borders();
    wr(0, 0, 32'h11111111);
    wr(0, 1, 32'h11111111);
    wr(0, 2, 32'h11111111);
    rd(0, 0, 1'b0, lat);
    checks++;
    if (bus.data_chunk !== {20'h11100, 20'h11100, 20'h11100, 20'h0, 20'h0}) begin
      errors++;
      $display("FAIL corner_zero: got %h want %h", bus.data_chunk, {20'h11100, 20'h11100, 20'h11100, 40'h0});
    end
    rd(0, 0, 1'b1, lat);
    checks++;
    if (bus.data_chunk !== {25{4'h1}}) begin
      errors++;
      $display("FAIL corner_clamp: got %h want all 1", bus.data_chunk);
    end
    wr(632, 100, 32'h9ABCDEF0);
    rd(1000, 100, 1'b1, lat);
    checks++;
    if (bus.data_chunk[59:40] !== 20'h999AB) begin
      errors++;
      $display("FAIL right_clamp: got %h want 999ab", bus.data_chunk[59:40]);
    end
    rd(1000, 100, 1'b0, lat);
    checks++;
    if (bus.data_chunk[59:40] !== 20'h009AB) begin
      errors++;
      $display("FAIL right_zero: got %h want 009ab", bus.data_chunk[59:40]);
    end
  endtask

  task automatic test_collision();
    int n = 0;
    wait_idle();
    bus.x_pos = 10'd0;
    bus.y_pos = 9'd3;
    bus.data_in = 32'h22222222;
    bus.write = 1'b1;
    bus.read = 1'b1;
    tick();
    bus.write = 1'b0;
    bus.read = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_busy: got %b want 1", bus.busy);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n += int'(bus.data_ready);
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL collision_no_ready: got %0d pulses want 0", n);
    end
    rd(2, 3, 1'b0, lat);
    checks++;
    if (bus.data_chunk[59:40] !== 20'h22222 || bus.data_chunk[39:20] !== 20'h11111) begin
      errors++;
      $display("FAIL collision_write: rows=%h/%h want 22222/11111", bus.data_chunk[59:40], bus.data_chunk[39:20]);
    end
  endtask

  task automatic test_wr_err();
    int n = 0;
    wait_idle();
    bus.x_pos = 10'd640;
    bus.y_pos = 9'd0;
    bus.data_in = 32'hFFFFFFFF;
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    checks++;
    if (bus.wr_err !== 1'b1) begin
      errors++;
      $display("FAIL wr_err_x: got %b want 1", bus.wr_err);
    end
    tick();
    checks++;
    if (bus.wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_err_pulse: got %b want 0", bus.wr_err);
    end
    bus.x_pos = 10'd0;
    bus.y_pos = 9'd480;
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    n += int'(bus.wr_err);
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(bus.wr_err);
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL wr_err_y: got %0d pulses want 1", n);
    end
    rd(2, 1, 1'b0, lat);
    checks++;
    if (bus.data_chunk[59:40] !== 20'h11111) begin
      errors++;
      $display("FAIL wr_err_ram: got %h want 11111", bus.data_chunk[59:40]);
    end
  endtask

  task automatic test_busy_ignore();
    int n = 0;
    wait_idle();
    bus.x_pos = 10'd2;
    bus.y_pos = 9'd3;
    bus.border_mode = 1'b0;
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    repeat (4) tick();
    bus.x_pos = 10'd0;
    bus.data_in = 32'h55555555;
    bus.write = 1'b1;
    bus.read = 1'b1;
    tick();
    n += int'(bus.data_ready);
    bus.write = 1'b0;
    bus.read = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n += int'(bus.data_ready);
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL busy_ignore_ready: got %0d pulses want 1", n);
    end
    rd(2, 3, 1'b0, lat);
    checks++;
    if (bus.data_chunk[59:40] !== 20'h22222) begin
      errors++;
      $display("FAIL busy_ignore_write: got %h want 22222", bus.data_chunk[59:40]);
    end
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    wait_idle();
    bus.x_pos = 10'd582;
    bus.y_pos = 9'd8;
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.data_ready !== 1'b0 || bus.data_chunk !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b ready=%b chunk=%h want all zero", bus.busy, bus.data_ready, bus.data_chunk);
    end
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n += int'(bus.data_ready);
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL reset_abandon: got %0d pulses want 0", n);
    end
  endtask

`ifdef FRAMEBUFFER_WINDOW_CLEAR_EN
  task automatic test_clear();
    int n = 0;
    wr(320, 240, 32'hFFFFFFFF);
    wr(312, 240, 32'hFFFFFFFF);
    wr(320, 239, 32'hFFFFFFFF);
    wait_idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    while (bus.busy && n < 40000) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 38400) begin
      errors++;
      $display("FAIL clear_busy: got %0d cycles want 38400", n);
    end
    rd(320, 240, 1'b0, lat);
    checks++;
    if (lat !== 12 || bus.data_chunk !== '0) begin
      errors++;
      $display("FAIL clear_read: lat=%0d chunk=%h want 12 and zero", lat, bus.data_chunk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_pattern();
    test_borders();
    test_collision();
    test_wr_err();
    test_busy_ignore();
    test_reset_mid_read();
`ifdef FRAMEBUFFER_WINDOW_CLEAR_EN
    test_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
